// File: rtl/countdown_arbiter_ctrl_pkg.sv
// rtl/countdown_arbiter_ctrl_pkg.sv - shared state encoding for the countdown arbiter controller
package countdown_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_arbiter_ctrl_rr_arbiter.sv
// rtl/countdown_arbiter_ctrl_rr_arbiter.sv - combinational round-robin pick starting at ptr
module countdown_arbiter_ctrl_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // Visit requesters in order ptr, ptr+1, ... wrapping mod NREQ; first hit wins.
    always_comb begin
        found    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/countdown_arbiter_ctrl.sv
// rtl/countdown_arbiter_ctrl.sv - round-robin sharing of one external down-counter among NREQ timer clients
module countdown_arbiter_ctrl
    import countdown_arbiter_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] delay,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt_in,
    output logic                  cnt_latch,
    output logic                  cnt_dec,
    input  logic                  cnt_zero
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] cnt_in_q, cnt_in_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    presc_q, presc_d;

    logic             arb_valid;
    logic [NREQ-1:0]  arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic [WIDTH-1:0] sel_delay;

    countdown_arbiter_ctrl_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .valid_o  (arb_valid),
        .onehot_o (arb_onehot),
        .idx_o    (arb_idx)
    );

    always_comb begin
        sel_delay = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_onehot[i]) begin
                sel_delay = delay[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_in_d = cnt_in_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        presc_d  = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d    = arb_onehot;
                    cnt_in_d = sel_delay;
                    idx_d    = arb_idx;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                presc_d = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                // The zero flag is trusted only after LOAD, so it is the sole exit condition.
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            cnt_in_q <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_in_q <= cnt_in_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            presc_q  <= presc_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign cnt_in    = cnt_in_q;
    assign cnt_latch = (state_q == ST_LOAD);
    assign cnt_dec   = (state_q == ST_COUNT) && !cnt_zero && (presc_q == PRESC_LAST);

endmodule

// File: tb/tb_countdown_arbiter_ctrl.sv
// tb/tb_countdown_arbiter_ctrl.sv - closed-loop bench: two controllers (P=1, P=3) each driving a 4-bit counter
module tb_countdown_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] delay;

    logic [3:0]  gnt_v[2];
    logic [3:0]  done_v[2];
    logic        busy_v[2];
    logic [3:0]  cnt_in_v[2];
    logic        latch_v[2];
    logic        dec_v[2];
    logic        zero_v[2];
    logic [3:0]  cnt_v[2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    countdown_arbiter_ctrl #(.NREQ(4), .WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .req(req), .delay(delay),
        .gnt(gnt_v[0]), .done(done_v[0]), .busy(busy_v[0]), .cnt_in(cnt_in_v[0]),
        .cnt_latch(latch_v[0]), .cnt_dec(dec_v[0]), .cnt_zero(zero_v[0])
    );

    countdown_arbiter_ctrl #(.NREQ(4), .WIDTH(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .req(req), .delay(delay),
        .gnt(gnt_v[1]), .done(done_v[1]), .busy(busy_v[1]), .cnt_in(cnt_in_v[1]),
        .cnt_latch(latch_v[1]), .cnt_dec(dec_v[1]), .cnt_zero(zero_v[1])
    );

    // External counter datapath: load/decrement, no reset, combinational zero flag.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (latch_v[i])    cnt_v[i] <= cnt_in_v[i];
            else if (dec_v[i]) cnt_v[i] <= cnt_v[i] - 4'd1;
        end
    end
    assign zero_v[0] = (cnt_v[0] == 4'd0);
    assign zero_v[1] = (cnt_v[1] == 4'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level reference: an operation granted at cycle 0 is described
    // purely by n = cycles since grant, the captured delay D and prescale P.
    int         m_active[2];
    int         m_n[2];
    int         m_w[2];
    int         m_d[2];
    int         m_ptr[2];
    logic [3:0] m_last[2];

    function automatic int pval(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [14:0] m_expect(input int i);
        int n, dd, p;
        logic [3:0] g, dn;
        logic lat, dc;
        if (m_active[i] == 0) return {11'b0, m_last[i]};
        n  = m_n[i];
        dd = m_d[i];
        p  = pval(i);
        g   = 4'(1 << m_w[i]);
        lat = (n == 1);
        dc  = (n >= 2) && (n - 2 < dd * p) && (((n - 2) % p) == p - 1);
        dn  = (n == 3 + dd * p) ? g : 4'b0;
        return {1'b1, g, dn, lat, dc, 4'(dd)};
    endfunction

    function automatic logic [14:0] dut_vec(input int i);
        return {busy_v[i], gnt_v[i], done_v[i], latch_v[i], dec_v[i], cnt_in_v[i]};
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_n[i] = 0; m_w[i] = 0; m_d[i] = 0; m_ptr[i] = 0; m_last[i] = 4'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_active[i] = 0; m_ptr[i] = 0; m_last[i] = 4'd0;
                end
                chk(i == 0 ? "model_p1" : "model_p3", 32'(dut_vec(i)), 32'(m_expect(i)));
                chk("latch_dec_overlap", 32'(latch_v[i] & dec_v[i]), 32'd0);
                if (rst_n) begin
                    if (m_active[i] != 0) begin
                        if (m_n[i] == 3 + m_d[i] * pval(i)) begin
                            m_active[i] = 0;
                            m_ptr[i] = (m_w[i] + 1) % 4;
                        end else begin
                            m_n[i]++;
                        end
                    end else if (req != 4'b0) begin
                        for (int k = 0; k < 4; k++) begin
                            if (m_active[i] == 0 && req[(m_ptr[i] + k) % 4]) begin
                                m_w[i] = (m_ptr[i] + k) % 4;
                                m_active[i] = 1;
                            end
                        end
                        m_n[i]    = 1;
                        m_d[i]    = int'(delay[m_w[i]*4 +: 4]);
                        m_last[i] = delay[m_w[i]*4 +: 4];
                    end
                end
            end
        end
    end

    logic [31:0] lat_m[2], dec_m[2], don_m[2];
    logic [3:0]  don_who[2];
    int          gorder[2][$];
    int          done_cnt[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs for cycle 0 are already applied; sample cycles 0..ncyc-1.
    task automatic observe(input int ncyc, input int drop_at);
        for (int i = 0; i < 2; i++) begin
            lat_m[i] = '0; dec_m[i] = '0; don_m[i] = '0; don_who[i] = '0;
            gorder[i].delete();
        end
        for (int r = 0; r < 4; r++) done_cnt[r] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (c < 32) begin
                    lat_m[i][c] = latch_v[i];
                    dec_m[i][c] = dec_v[i];
                    don_m[i][c] = |done_v[i];
                end
                don_who[i] = don_who[i] | done_v[i];
                if (latch_v[i]) begin
                    for (int r = 0; r < 4; r++) if (gnt_v[i][r]) gorder[i].push_back(r);
                end
            end
            if (c <= 25) for (int r = 0; r < 4; r++) if (done_v[0][r]) done_cnt[r]++;
            step();
            if (c + 1 == drop_at) req = 4'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        delay = 16'h0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single requester 0, delay 5
        req = 4'b0001; delay = 16'h0005;
        observe(20, 1);
        chk("t2_latch", lat_m[0], 32'h2);
        chk("t2_dec",   dec_m[0], 32'h7C);
        chk("t2_done",  don_m[0], 32'h100);
        chk("t2_who",   32'(don_who[0]), 32'h1);

        // Requester 2, delay 0: no decrement at all
        req = 4'b0100; delay = 16'h0000;
        observe(8, 1);
        for (int i = 0; i < 2; i++) begin
            chk("t3_latch", lat_m[i], 32'h2);
            chk("t3_dec",   dec_m[i], 32'h0);
            chk("t3_done",  don_m[i], 32'h8);
            chk("t3_who",   32'(don_who[i]), 32'h4);
        end

        // Delay 2, request dropped at cycle 4
        req = 4'b0001; delay = 16'h0002;
        observe(12, 4);
        chk("t5_p3_latch", lat_m[1], 32'h2);
        chk("t5_p3_dec",   dec_m[1], 32'h90);
        chk("t5_p3_done",  don_m[1], 32'h200);
        chk("t5_p1_dec",   dec_m[0], 32'h0C);
        chk("t5_p1_done",  don_m[0], 32'h20);

        // Reset during COUNT of a long operation
        req = 4'b0001; delay = 16'h000F;
        observe(5, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_rst_p1", 32'(dut_vec(0)), 32'd0);
        chk("t1_rst_p3", 32'(dut_vec(1)), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // All requesting, delays 1..4: fair rotation from pointer 0
        req = 4'b1111; delay = {4'd4, 4'd3, 4'd2, 4'd1};
        observe(50, 0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_rounds", 32'(gorder[i].size() >= 5), 32'd1);
            if (gorder[i].size() >= 5) begin
                for (int k = 0; k < 5; k++) chk("t4_order", 32'(gorder[i][k]), 32'(k % 4));
            end
        end
        for (int r = 0; r < 4; r++) chk("t4_done_once", 32'(done_cnt[r]), 32'd1);
        req = 4'b0;
        repeat (60) step();

        // Randomised traffic with occasional asynchronous resets
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 2) == 0) delay = 16'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
